// File: rtl/fetch_controller.sv
// fetch_controller: sequences the instruction-fetch stage (boot hold, load-use
// stalls, taken-branch redirects, halt) and keeps saturating perf counters.
module fetch_controller #(
    parameter int BOOT_CYCLES = 2,
    parameter int STALL_LIMIT = 16,
    parameter int CNT_W       = 32,
    parameter int WORD_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hazard_stall,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target_in,
    input  logic              halt_detect,
    input  logic              resume,
    output logic              pc_src,
    output logic [WORD_W-1:0] branch_target,
    output logic              pc_write_en,
    output logic              if_id_write_en,
    output logic              flush,
    output logic              halted,
    output logic              stall_timeout,
    output logic [CNT_W-1:0]  fetch_count,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  redirect_count
);

    typedef enum logic [1:0] {BOOT, RUN, REDIRECT, HALT} state_t;

    localparam int WD_W = $clog2(STALL_LIMIT + 1);
    localparam logic [7:0]      BOOT_LAST = 8'(BOOT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX    = WD_W'(STALL_LIMIT);
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(STALL_LIMIT - 1);

    state_t              state_reg, state_next;
    logic [7:0]          boot_cnt_reg;
    logic [WORD_W-1:0]   target_reg;
    logic [WD_W-1:0]     wd_reg;
    logic                timeout_reg;
    logic                latch_target;
    logic [2:0]          cnt_event;
    logic [CNT_W-1:0]    cnt_reg [3];

    // Next-state and per-state output decode; outputs default to a quiet pipeline.
    always_comb begin
        state_next     = state_reg;
        pc_src         = 1'b0;
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        flush          = 1'b0;
        halted         = 1'b0;
        latch_target   = 1'b0;
        case (state_reg)
            BOOT: begin
                flush = 1'b1;
                if (boot_cnt_reg == BOOT_LAST) state_next = RUN;
            end
            RUN: begin
                // Stall takes effect in the same cycle it is raised.
                pc_write_en    = !hazard_stall;
                if_id_write_en = !hazard_stall;
                if (branch_taken) begin
                    state_next   = REDIRECT;
                    latch_target = 1'b1;
                end else if (halt_detect) begin
                    state_next = HALT;
                end
            end
            REDIRECT: begin
                // Stalls and younger branches are on the squashed path here.
                pc_src         = 1'b1;
                pc_write_en    = 1'b1;
                if_id_write_en = 1'b1;
                flush          = 1'b1;
                state_next     = RUN;
            end
            HALT: begin
                halted = 1'b1;
                // A taken branch means the halt itself was fetched on the wrong path.
                if (branch_taken) begin
                    state_next   = REDIRECT;
                    latch_target = 1'b1;
                end else if (resume) begin
                    state_next = RUN;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    // State register and boot bubble counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= BOOT;
            boot_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            boot_cnt_reg <= (state_reg == BOOT) ? boot_cnt_reg + 8'd1 : 8'd0;
        end
    end

    // Redirect target capture, only on an accepted branch.
    always_ff @(posedge clk) begin
        if (reset) begin
            target_reg <= '0;
        end else if (latch_target) begin
            target_reg <= branch_target_in;
        end
    end

    // Watchdog over consecutive stalled RUN cycles; timeout flag is sticky.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_reg      <= '0;
            timeout_reg <= 1'b0;
        end else if (state_reg == RUN && hazard_stall) begin
            if (wd_reg != WD_MAX) wd_reg <= wd_reg + 1'b1;
            if (wd_reg >= WD_LAST) timeout_reg <= 1'b1;
        end else begin
            wd_reg <= '0;
        end
    end

    // Counter events: 0 = accepted fetch, 1 = stall cycle, 2 = redirect entry.
    assign cnt_event[0] = pc_write_en && (state_reg != BOOT);
    assign cnt_event[1] = (state_reg == RUN) && hazard_stall && !branch_taken;
    assign cnt_event[2] = latch_target;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            // Saturating performance counter.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_event[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign branch_target  = target_reg;
    assign stall_timeout  = timeout_reg;
    assign fetch_count    = cnt_reg[0];
    assign stall_count    = cnt_reg[1];
    assign redirect_count = cnt_reg[2];

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: table-driven directed vectors plus hand-written
// sequences for the stall watchdog and reset-during-redirect.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        hazard_stall, branch_taken, halt_detect, resume;
    logic [31:0] branch_target_in;
    logic        pc_src, pc_write_en, if_id_write_en, flush, halted, stall_timeout;
    logic [31:0] branch_target, fetch_count, stall_count, redirect_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_controller dut (
        .clk(clk), .reset(reset), .hazard_stall(hazard_stall),
        .branch_taken(branch_taken), .branch_target_in(branch_target_in),
        .halt_detect(halt_detect), .resume(resume), .pc_src(pc_src),
        .branch_target(branch_target), .pc_write_en(pc_write_en),
        .if_id_write_en(if_id_write_en), .flush(flush), .halted(halted),
        .stall_timeout(stall_timeout), .fetch_count(fetch_count),
        .stall_count(stall_count), .redirect_count(redirect_count)
    );

    typedef struct {
        logic        h, b;
        logic [31:0] t;
        logic        d, s;
        logic        src;
        logic [31:0] tgt;
        logic        pwe, fl, hl;
        int          fc, sc, rc;
    } vec_t;

    vec_t vecs[28];

    function automatic vec_t mk(input logic h, b, input logic [31:0] t, input logic d, s,
                                input logic src, input logic [31:0] tgt,
                                input logic pwe, fl, hl, input int fc, sc, rc);
        vec_t v;
        v.h = h; v.b = b; v.t = t; v.d = d; v.s = s;
        v.src = src; v.tgt = tgt; v.pwe = pwe; v.fl = fl; v.hl = hl;
        v.fc = fc; v.sc = sc; v.rc = rc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        hazard_stall = 0; branch_taken = 0; halt_detect = 0; resume = 0;
        branch_target_in = 0;
    endtask

    initial begin
        //                h  b  t    d  s   src tgt  pwe fl hl  fc  sc rc
        vecs[0]  = mk(0, 0, 0,   0, 0,  0, 0,   0, 1, 0,  0, 0, 0); // BOOT
        vecs[1]  = mk(0, 0, 0,   0, 0,  0, 0,   0, 1, 0,  0, 0, 0); // BOOT
        vecs[2]  = mk(0, 0, 0,   0, 0,  0, 0,   1, 0, 0,  0, 0, 0); // RUN
        vecs[3]  = mk(0, 0, 0,   0, 0,  0, 0,   1, 0, 0,  1, 0, 0);
        vecs[4]  = mk(0, 0, 0,   0, 0,  0, 0,   1, 0, 0,  2, 0, 0);
        vecs[5]  = mk(0, 1, 44,  0, 0,  0, 0,   1, 0, 0,  3, 0, 0); // branch 44
        vecs[6]  = mk(0, 0, 0,   0, 0,  1, 44,  1, 1, 0,  4, 0, 1); // REDIRECT
        vecs[7]  = mk(0, 0, 0,   0, 0,  0, 44,  1, 0, 0,  5, 0, 1);
        vecs[8]  = mk(0, 1, 20,  0, 0,  0, 44,  1, 0, 0,  6, 0, 1); // branch 20
        vecs[9]  = mk(0, 1, 32,  0, 0,  1, 20,  1, 1, 0,  7, 0, 2); // ignored 32
        vecs[10] = mk(0, 0, 0,   0, 0,  0, 20,  1, 0, 0,  8, 0, 2);
        vecs[11] = mk(1, 0, 0,   0, 0,  0, 20,  0, 0, 0,  9, 0, 2); // stall x3
        vecs[12] = mk(1, 0, 0,   0, 0,  0, 20,  0, 0, 0,  9, 1, 2);
        vecs[13] = mk(1, 0, 0,   0, 0,  0, 20,  0, 0, 0,  9, 2, 2);
        vecs[14] = mk(0, 0, 0,   0, 0,  0, 20,  1, 0, 0,  9, 3, 2);
        vecs[15] = mk(0, 0, 0,   1, 0,  0, 20,  1, 0, 0, 10, 3, 2); // halt_detect
        vecs[16] = mk(0, 0, 0,   0, 0,  0, 20,  0, 0, 1, 11, 3, 2); // HALT
        vecs[17] = mk(0, 0, 0,   0, 0,  0, 20,  0, 0, 1, 11, 3, 2);
        vecs[18] = mk(0, 1, 8,   0, 0,  0, 20,  0, 0, 1, 11, 3, 2); // branch 8 in HALT
        vecs[19] = mk(0, 0, 0,   0, 0,  1, 8,   1, 1, 0, 11, 3, 3); // REDIRECT
        vecs[20] = mk(0, 0, 0,   0, 0,  0, 8,   1, 0, 0, 12, 3, 3);
        vecs[21] = mk(0, 0, 0,   1, 0,  0, 8,   1, 0, 0, 13, 3, 3); // halt_detect
        vecs[22] = mk(0, 0, 0,   0, 1,  0, 8,   0, 0, 1, 14, 3, 3); // resume
        vecs[23] = mk(0, 0, 0,   0, 0,  0, 8,   1, 0, 0, 14, 3, 3); // RUN again
        vecs[24] = mk(1, 1, 100, 1, 0,  0, 8,   0, 0, 0, 15, 3, 3); // all at once
        vecs[25] = mk(1, 0, 0,   1, 0,  1, 100, 1, 1, 0, 15, 3, 4); // REDIRECT ignores h/d
        vecs[26] = mk(0, 0, 0,   0, 0,  0, 100, 1, 0, 0, 16, 3, 4);
        vecs[27] = mk(0, 0, 0,   0, 0,  0, 100, 1, 0, 0, 17, 3, 4);

        idle_inputs();
        reset = 1;
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("[TB] reset state");
        chk("rst_pc_src", pc_src, 0);
        chk("rst_branch_target", branch_target, 0);
        chk("rst_pc_write_en", pc_write_en, 0);
        chk("rst_if_id_write_en", if_id_write_en, 0);
        chk("rst_flush", flush, 1);
        chk("rst_halted", halted, 0);
        chk("rst_stall_timeout", stall_timeout, 0);
        chk("rst_counts", {fetch_count, stall_count} | redirect_count, 0);

        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            reset = 0;
            hazard_stall = vecs[i].h; branch_taken = vecs[i].b;
            branch_target_in = vecs[i].t; halt_detect = vecs[i].d; resume = vecs[i].s;
            #1;
            $display("[TB] vec %0d: src=%0d tgt=%0d pwe=%0d fl=%0d hl=%0d fc=%0d sc=%0d rc=%0d",
                     i, pc_src, branch_target, pc_write_en, flush, halted,
                     fetch_count, stall_count, redirect_count);
            chk($sformatf("v%0d_pc_src", i), pc_src, vecs[i].src);
            chk($sformatf("v%0d_branch_target", i), branch_target, vecs[i].tgt);
            chk($sformatf("v%0d_pc_write_en", i), pc_write_en, vecs[i].pwe);
            chk($sformatf("v%0d_if_id_write_en", i), if_id_write_en, vecs[i].pwe);
            chk($sformatf("v%0d_flush", i), flush, vecs[i].fl);
            chk($sformatf("v%0d_halted", i), halted, vecs[i].hl);
            chk($sformatf("v%0d_stall_timeout", i), stall_timeout, 0);
            chk($sformatf("v%0d_fetch_count", i), fetch_count, 64'(vecs[i].fc));
            chk($sformatf("v%0d_stall_count", i), stall_count, 64'(vecs[i].sc));
            chk($sformatf("v%0d_redirect_count", i), redirect_count, 64'(vecs[i].rc));
        end

        // Watchdog: 16 consecutive stalled RUN cycles set the sticky timeout.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            idle_inputs();
            hazard_stall = 1;
            #1;
            $display("[TB] stall cycle %0d: timeout=%0d", i, stall_timeout);
            chk($sformatf("wd_%0d_timeout", i), stall_timeout, 0);
            chk($sformatf("wd_%0d_pc_write_en", i), pc_write_en, 0);
        end
        @(negedge clk);
        hazard_stall = 0;
        #1;
        $display("[TB] stall released: timeout=%0d sc=%0d", stall_timeout, stall_count);
        chk("wd_timeout_set", stall_timeout, 1);
        chk("wd_stall_count", stall_count, 19);
        chk("wd_fetch_count", fetch_count, 18);
        @(negedge clk);
        #1;
        $display("[TB] after stall: timeout=%0d fc=%0d", stall_timeout, fetch_count);
        chk("wd_timeout_sticky", stall_timeout, 1);
        chk("wd_fetch_count2", fetch_count, 19);

        // Reset asserted during REDIRECT discards target and counters.
        @(negedge clk);
        branch_taken = 1; branch_target_in = 55;
        #1;
        @(negedge clk);
        branch_taken = 0; branch_target_in = 0; reset = 1;
        #1;
        $display("[TB] redirect before reset: src=%0d tgt=%0d", pc_src, branch_target);
        chk("rr_pc_src", pc_src, 1);
        chk("rr_branch_target", branch_target, 55);
        @(negedge clk);
        reset = 0;
        branch_taken = 1; branch_target_in = 77;   // ignored in BOOT
        #1;
        $display("[TB] after reset: src=%0d tgt=%0d fl=%0d", pc_src, branch_target, flush);
        chk("rr_boot_pc_src", pc_src, 0);
        chk("rr_boot_target", branch_target, 0);
        chk("rr_boot_flush", flush, 1);
        chk("rr_boot_fetch_count", fetch_count, 0);
        chk("rr_boot_stall_count", stall_count, 0);
        chk("rr_boot_redirect_count", redirect_count, 0);
        chk("rr_boot_timeout", stall_timeout, 0);
        @(negedge clk);
        branch_taken = 0; branch_target_in = 0;
        #1;
        $display("[TB] boot cycle 2: src=%0d pwe=%0d fl=%0d", pc_src, pc_write_en, flush);
        chk("bb_pc_src", pc_src, 0);
        chk("bb_flush", flush, 1);
        chk("bb_target", branch_target, 0);
        @(negedge clk);
        #1;
        $display("[TB] first run: src=%0d pwe=%0d rc=%0d", pc_src, pc_write_en, redirect_count);
        chk("bb_run_pwe", pc_write_en, 1);
        chk("bb_run_pc_src", pc_src, 0);
        chk("bb_run_redirect_count", redirect_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "time limit");
    end

endmodule
